// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with a Start/Done handshake, an N/Z/C/V flag register,
// iterative 1-bit-per-cycle shifts and a shift-add multiplier.
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   Start           request, accepted only while Busy=0
//   CtrlFunc, A, B  operation select and operands, sampled with Start
//   Busy            high while a multi-cycle op runs (RUN and its FIN cycle)
//   Done            one-cycle pulse; Result/Flags valid in the same cycle
//   Result          registered result, held until the next Done
//   Flags           registered {N,Z,C,V}, held between updates
module alu_seq #(
    parameter int unsigned WIDTH         = 32,
    parameter bit          FLAGS_ALL_OPS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       CtrlFunc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);

    localparam int unsigned SW   = $clog2(WIDTH);
    localparam int unsigned CW   = $clog2(WIDTH + 1);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned MSB  = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // single-cycle datapath on the live inputs
    logic [WIDTH:0]     sum_w, dif_w;
    logic [WIDTH-1:0]   one_res;
    logic               one_c, one_v, one_multi, one_fwr;
    logic [SW-1:0]      shamt;

    // one iteration of the running multi-cycle op
    logic [WIDTH-1:0]   step_val, step_acc, fin_res;
    logic               step_c, fin_c;

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;
    assign Flags  = flags_q;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        return {r[MSB], (r == '0), c, v};
    endfunction

    // result, carry and overflow of an op that completes in its accept cycle
    always_comb begin
        sum_w     = {1'b0, A} + {1'b0, B};
        dif_w     = {1'b0, A} - {1'b0, B};
        shamt     = B[SW-1:0];
        one_res   = '0;
        one_c     = 1'b0;
        one_v     = 1'b0;
        one_multi = 1'b0;
        one_fwr   = FLAGS_ALL_OPS ? (CtrlFunc < 4'd12) : (CtrlFunc == OP_CMP);
        case (CtrlFunc)
            4'd0:   one_res = A & B;
            4'd1:   one_res = A | B;
            4'd2:   one_res = A ^ B;
            OP_ADD: begin
                one_res = sum_w[WIDTH-1:0];
                one_c   = sum_w[WIDTH];
                one_v   = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
            end
            OP_SUB, OP_CMP: begin
                one_res = dif_w[WIDTH-1:0];
                one_c   = ~dif_w[WIDTH];
                one_v   = (A[MSB] != B[MSB]) && (dif_w[MSB] != A[MSB]);
            end
            4'd6:   one_res = ~A;
            4'd7:   one_res = {A[HALF-1:0], {HALF{1'b0}}};
            OP_SLL, OP_SRL, OP_SRA: begin
                one_res   = A;
                one_multi = (shamt != '0);
            end
            OP_MUL: one_multi = 1'b1;
            default: one_res = '0;
        endcase
    end

    // one shift step (shift ops) or one shift-add step (MUL)
    always_comb begin
        step_acc = acc_q + (opb_q[0] ? opa_q : '0);
        step_val = opa_q << 1;
        step_c   = opa_q[MSB];
        case (op_q)
            OP_SRL: begin
                step_val = opa_q >> 1;
                step_c   = opa_q[0];
            end
            OP_SRA: begin
                step_val = {opa_q[MSB], opa_q[WIDTH-1:1]};
                step_c   = opa_q[0];
            end
            default: ;
        endcase
        fin_res = (op_q == OP_MUL) ? step_acc : step_val;
        fin_c   = (op_q == OP_MUL) ? 1'b0 : step_c;
    end

    // next-state and register-input logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = step_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    opa_d = step_val;
                end
                if (cnt_q == CW'(1)) begin
                    state_d  = FIN;
                    result_d = fin_res;
                    if (FLAGS_ALL_OPS) begin
                        flags_d = mk_flags(fin_res, fin_c, 1'b0);
                    end
                    done_d = 1'b1;
                end
            end
            default: begin
                // IDLE, and FIN after a single-cycle op (Busy=0), accept Start
                state_d = IDLE;
                busy_d  = 1'b0;
                if (Start && !busy_q) begin
                    op_d = CtrlFunc;
                    if (one_multi) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        opa_d   = A;
                        opb_d   = B;
                        acc_d   = '0;
                        cnt_d   = (CtrlFunc == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
                    end else begin
                        state_d  = FIN;
                        result_d = one_res;
                        if (one_fwr) begin
                            flags_d = mk_flags(one_res, one_c, one_v);
                        end
                        done_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule
